// File: rtl/hilo_unit.sv
// Execute-stage HI/LO register unit: mthi/mtlo/mfhi/mflo plus mult/multu/madd/msub.
// Default build uses a 32-step shift-add multiplier; define HILO_FAST_MUL_EN for a single-cycle product.
module hilo_unit (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [4:0]  ALUControl,
    input  logic        HWrite,
    input  logic        LWrite,
    input  logic        HLRead,
    input  logic        HiSel,
    input  logic        LoSel,
    input  logic        AddSubSel,
    input  logic        Add,
    input  logic        HLRegSel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] ReadData,
    output logic        Busy,
    output logic        Stall,
    output logic [1:0]  dbg_state
);

    logic [31:0] hi, lo;
    logic        is_unsigned, is_mthi, is_mtlo, is_mul, is_macc, issue;

    // Handshake: an instruction is accepted when Start=1 and Busy=0; otherwise
    // Stall is raised and the pipeline must hold and re-present it.
    assign is_unsigned = (ALUControl == 5'd18);
    assign is_mthi     = HWrite & HiSel;
    assign is_mtlo     = LWrite & LoSel;
    assign is_mul      = HWrite & LWrite & ~AddSubSel & ~HiSel & ~LoSel;
    assign is_macc     = HWrite & LWrite & AddSubSel;
    assign issue       = Start & ~Busy;
    assign ReadData    = HLRegSel ? hi : lo;

`ifdef HILO_FAST_MUL_EN
    logic [63:0] sprod, uprod, prod;
    logic        unused_fast;

    assign sprod       = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign uprod       = {32'd0, A} * {32'd0, B};
    assign prod        = is_unsigned ? uprod : sprod;
    assign Busy        = 1'b0;
    assign Stall       = 1'b0;
    assign dbg_state   = 2'd0;
    assign unused_fast = HLRead;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (issue) begin
            if (is_mul) begin
                {hi, lo} <= prod;
            end else if (is_macc) begin
                {hi, lo} <= Add ? ({hi, lo} + prod) : ({hi, lo} - prod);
            end else begin
                if (is_mthi) hi <= A;
                if (is_mtlo) lo <= A;
            end
        end
    end
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, WB = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] mcand, mplier, a_mag, b_mag;
    logic [63:0] prod, res;
    logic        sign, acc_op, add_op, signed_op;

    // Two's-complement negation of 0x80000000 yields 0x80000000, which read as
    // unsigned is exactly 2^31, so the magnitude path needs no extra bit.
    assign signed_op = ~is_unsigned;
    assign a_mag     = (signed_op & A[31]) ? (32'd0 - A) : A;
    assign b_mag     = (signed_op & B[31]) ? (32'd0 - B) : B;
    assign res       = sign ? (64'd0 - prod) : prod;
    assign Busy      = (state != IDLE);
    assign Stall     = Start & (Busy | (HLRead & Busy));
    assign dbg_state = state;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue & (is_mul | is_macc)) state_nxt = MULT;
            MULT:    if (cnt == 5'd31) state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hi     <= 32'd0;
            lo     <= 32'd0;
            cnt    <= 5'd0;
            mcand  <= 32'd0;
            mplier <= 32'd0;
            prod   <= 64'd0;
            sign   <= 1'b0;
            acc_op <= 1'b0;
            add_op <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        if (is_mul | is_macc) begin
                            mcand  <= a_mag;
                            mplier <= b_mag;
                            prod   <= 64'd0;
                            cnt    <= 5'd0;
                            sign   <= signed_op & (A[31] ^ B[31]);
                            acc_op <= is_macc;
                            add_op <= Add;
                        end else begin
                            if (is_mthi) hi <= A;
                            if (is_mtlo) lo <= A;
                        end
                    end
                end
                MULT: begin
                    if (mplier[cnt]) prod <= prod + ({32'd0, mcand} << cnt);
                    cnt <= cnt + 5'd1;
                end
                WB: begin
                    if (acc_op) {hi, lo} <= add_op ? ({hi, lo} + res) : ({hi, lo} - res);
                    else        {hi, lo} <= res;
                end
                default: ;
            endcase
        end
    end
`endif

endmodule
